cache_fill_fsm: RTL and testbench

Cache miss-fill controller sitting directly upstream of the multi-cycle main memory. On a cache miss it captures the block address and streams one read request per cycle for every word of the block into the memory's 4-deep read pipeline. It counts the returning `data_valid` beats and steers each word into the cache data array. It then writes the tag and releases the pipeline stall.

---
 rtl/cache_fill_fsm.sv | 92 +++++++++
 tb/tb_cache_fill_fsm.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: streams one read per word of the missing block
// into the memory read pipeline and steers the returning beats into the data array.
module cache_fill_fsm #(
   parameter int ADDR_WIDTH = 16,
   parameter int WORD_BITS  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  miss_detected,
   input  logic [ADDR_WIDTH-1:0] miss_address,
   output logic                  fsm_busy,
   output logic                  memory_enable,
   output logic [ADDR_WIDTH-1:0] memory_address,
   input  logic                  memory_data_valid,
   input  logic [15:0]           memory_data,
   output logic                  write_data_array,
   output logic [WORD_BITS-1:0]  fill_word,
   output logic [15:0]           fill_data,
   output logic                  write_tag_array,
   output logic                  fill_done
);

   localparam int BASE_W = ADDR_WIDTH - WORD_BITS - 1;
   localparam int CNT_W  = WORD_BITS + 1;

   localparam logic [CNT_W-1:0] N_WORDS   = {1'b1, {WORD_BITS{1'b0}}};
   localparam logic [CNT_W-1:0] LAST_WORD = {1'b0, {WORD_BITS{1'b1}}};

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_FILL = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [BASE_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;

   logic in_fill;
   logic accept;
   logic last_beat;

   assign in_fill   = (state_q == S_FILL);
   // Only beats that were actually requested count; anything else on the bus is noise.
   assign accept    = in_fill && memory_data_valid && (recv_cnt_q < issue_cnt_q);
   assign last_beat = accept && (recv_cnt_q == LAST_WORD);

   assign fsm_busy         = in_fill || ((state_q == S_IDLE) && miss_detected);
   assign memory_enable    = in_fill && (issue_cnt_q < N_WORDS);
   assign memory_address   = in_fill ? {base_q, issue_cnt_q[WORD_BITS-1:0], 1'b0} : '0;
   assign write_data_array = accept;
   assign fill_word        = in_fill ? recv_cnt_q[WORD_BITS-1:0] : '0;
   assign fill_data        = memory_data;
   assign write_tag_array  = last_beat;
   assign fill_done        = last_beat;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (miss_detected) begin
               base_d      = miss_address[ADDR_WIDTH-1:WORD_BITS+1];
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
               state_d     = S_FILL;
            end
         end
         S_FILL: begin
            if (memory_enable) issue_cnt_d = issue_cnt_q + 1'b1;
            if (accept)        recv_cnt_d  = recv_cnt_q + 1'b1;
            if (last_beat)     state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
      end
   end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a 4-cycle memory model feeds the DUT and
// expected issue/write events, stamped with their cycle numbers, are checked on the falling edge.
module tb_cache_fill_fsm;

   localparam int AW = 16;
   localparam int WB = 3;
   localparam int NW = 8;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
   } en_t;

   typedef struct {
      int          cyc;
      logic [2:0]  word;
      logic [15:0] data;
      bit          last;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          miss_detected = 1'b0;
   logic [AW-1:0] miss_address = '0;
   logic          fsm_busy;
   logic          memory_enable;
   logic [AW-1:0] memory_address;
   logic          memory_data_valid;
   logic [15:0]   memory_data;
   logic          write_data_array;
   logic [WB-1:0] fill_word;
   logic [15:0]   fill_data;
   logic          write_tag_array;
   logic          fill_done;

   logic          inj_valid = 1'b0;
   logic [15:0]   noise = '0;
   logic [15:0]   mem [0:32767];
   bit            pv [4];
   bit   [15:0]   pa [4];

   int  cyc = 0;
   int  free_cyc = 0;
   int  busy_end = -1;
   int  last_start = -100;
   int  errors = 0;
   int  checks = 0;
   en_t enq[$];
   wr_t wrq[$];

   cache_fill_fsm #(.ADDR_WIDTH(AW), .WORD_BITS(WB)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .fsm_busy          (fsm_busy),
      .memory_enable     (memory_enable),
      .memory_address    (memory_address),
      .memory_data_valid (memory_data_valid),
      .memory_data       (memory_data),
      .write_data_array  (write_data_array),
      .fill_word         (fill_word),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array),
      .fill_done         (fill_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory: enable in cycle n yields data_valid in cycle n+4.
   always @(posedge clk) begin
      pv[0] <= memory_enable;
      pa[0] <= memory_address;
      for (int i = 1; i < 4; i++) begin
         pv[i] <= pv[i-1];
         pa[i] <= pa[i-1];
      end
   end
   assign memory_data_valid = pv[3] | inj_valid;
   assign memory_data       = pv[3] ? mem[pa[3][15:1]] : noise;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic fail(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
   endtask

   // Reference: a miss accepted in cycle c reads block words in cycles c+1..c+8,
   // receives them in c+5..c+12, completes in c+12 and is free again in c+13.
   task automatic accept_miss(input logic [15:0] a);
      logic [15:0] base;
      base = a & 16'hFFF0;
      for (int i = 0; i < NW; i++) begin
         logic [15:0] wa;
         wa = base + 16'(2 * i);
         enq.push_back('{cyc + 1 + i, wa});
         wrq.push_back('{cyc + 5 + i, 3'(i), mem[wa[15:1]], (i == NW - 1)});
      end
      busy_end   = cyc + 12;
      free_cyc   = cyc + 13;
      last_start = cyc;
   endtask

   task automatic step(input bit m, input logic [15:0] a, input bit inj_req);
      bit may_inject;
      @(posedge clk);
      #1;
      may_inject    = (cyc >= free_cyc) || (cyc == last_start + 1);
      miss_detected = m;
      miss_address  = a;
      inj_valid     = inj_req && may_inject;
      noise         = 16'($urandom);
      if (m && rst_n && (cyc >= free_cyc)) accept_miss(a);
   endtask

   always @(negedge clk) begin
      en_t e;
      wr_t w;
      while (enq.size() > 0 && enq[0].cyc < cyc) begin
         fail("enable_missing", 32'(enq[0].addr), 32'(enq[0].cyc));
         void'(enq.pop_front());
      end
      while (wrq.size() > 0 && wrq[0].cyc < cyc) begin
         fail("write_missing", 32'(wrq[0].word), 32'(wrq[0].cyc));
         void'(wrq.pop_front());
      end
      if (memory_enable) begin
         if (enq.size() > 0 && enq[0].cyc == cyc) begin
            e = enq.pop_front();
            chk("memory_address", 32'(memory_address), 32'(e.addr));
         end else begin
            fail("enable_unexpected", 32'(memory_address), 32'(0));
         end
      end
      if (write_data_array) begin
         if (wrq.size() > 0 && wrq[0].cyc == cyc) begin
            w = wrq.pop_front();
            chk("fill_word", 32'(fill_word), 32'(w.word));
            chk("fill_data", 32'(fill_data), 32'(w.data));
            chk("write_tag_array", 32'(write_tag_array), 32'(w.last));
            chk("fill_done", 32'(fill_done), 32'(w.last));
         end else begin
            fail("write_unexpected", 32'(fill_word), 32'(0));
         end
      end else begin
         chk("tag_done_no_write", 32'({write_tag_array, fill_done}), 32'(0));
      end
      chk("fsm_busy", 32'(fsm_busy), 32'((cyc <= busy_end) || miss_detected));
      chk("fill_data_passthru", 32'(fill_data), 32'(memory_data));
   end

   initial begin
      int c0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < NW; i++) mem[(16'h1230 >> 1) + i] = 16'hA000 + 16'(i);

      repeat (3) step(1'b0, '0, 1'b0);
      rst_n = 1'b1;

      // Idle after reset, with spurious beats that must not produce strobes
      for (int i = 0; i < 20; i++) step(1'b0, '0, (i % 3) == 0);

      // Single miss, spurious beat in the first FILL cycle
      step(1'b1, 16'h1236, 1'b0);
      step(1'b0, '0, 1'b1);
      repeat (14) step(1'b0, '0, 1'b0);

      // Miss held through the fill, address changed mid-fill
      step(1'b1, 16'h1236, 1'b0);
      for (int k = 1; k <= 13; k++) step(1'b1, (k >= 3) ? 16'h4000 : 16'h1236, 1'b0);
      repeat (15) step(1'b0, '0, 1'b0);

      // Top of the address space
      step(1'b1, 16'hFFFF, 1'b0);
      repeat (15) step(1'b0, '0, 1'b0);

      // Reset in cycle 6 of a fill, released in cycle 11, new miss in cycle 12
      step(1'b1, 16'h0100, 1'b0);
      c0 = cyc;
      repeat (6) step(1'b0, '0, 1'b0);
      #6;
      rst_n = 1'b0;
      enq.delete();
      wrq.delete();
      busy_end = -1;
      free_cyc = 0;
      #1;
      chk("rst_memory_enable", 32'(memory_enable), 32'(0));
      chk("rst_memory_address", 32'(memory_address), 32'(0));
      chk("rst_write_data_array", 32'(write_data_array), 32'(0));
      chk("rst_fill_word", 32'(fill_word), 32'(0));
      chk("rst_tag_done", 32'({write_tag_array, fill_done}), 32'(0));
      chk("rst_fsm_busy", 32'(fsm_busy), 32'(0));
      while (cyc < c0 + 11) step(1'b0, '0, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 16'h0020, 1'b0);
      repeat (15) step(1'b0, '0, 1'b0);

      // Randomized misses, addresses and spurious beats
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 2) == 0);
      repeat (20) step(1'b0, '0, 1'b0);

      chk("enable_queue_drained", 32'(enq.size()), 32'(0));
      chk("write_queue_drained", 32'(wrq.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
